// File: rtl/pio_sm_array_ctrl.sv
// rtl/pio_sm_array_ctrl.sv - shared instruction memory, clock dividers and pin arbitration for PIO state machines
//
// Purpose: serves NUM_SM state-machine channels with a shared 16-bit
// instruction memory (one write port, NUM_SM combinational read ports),
// a per-channel fractional-free clock divider that produces execute-step
// strobes, restart pulse generation and highest-index-wins pin arbitration.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imem_wr_en/addr/data          instruction memory write port
//   sm_pc      -> sm_instr        per-channel fetch (channel i in slice i)
//   sm_enable, sm_restart         per-channel run enable / restart request
//   div_wr_en, div_value          per-channel divider load (shared value)
//   sm_clk_en, sm_restart_out     per-channel step strobe / restart pulse
//   sm_output, sm_drive           per-channel pin values / drive enables
//   core_output, core_drive       arbitrated pin value / drive enable
//
// Configuration macro: PIO_OUT_REG_EN registers core_output/core_drive.
module pio_sm_array_ctrl #(
    parameter int NUM_SM  = 4,
    parameter int IMEM_AW = 5,
    parameter int GPIO_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      imem_wr_en,
    input  logic [IMEM_AW-1:0]        imem_wr_addr,
    input  logic [15:0]               imem_wr_data,
    input  logic [NUM_SM*IMEM_AW-1:0] sm_pc,
    output logic [NUM_SM*16-1:0]      sm_instr,
    input  logic [NUM_SM-1:0]         sm_enable,
    input  logic [NUM_SM-1:0]         sm_restart,
    input  logic [NUM_SM-1:0]         div_wr_en,
    input  logic [15:0]               div_value,
    output logic [NUM_SM-1:0]         sm_clk_en,
    output logic [NUM_SM-1:0]         sm_restart_out,
    input  logic [NUM_SM*GPIO_W-1:0]  sm_output,
    input  logic [NUM_SM*GPIO_W-1:0]  sm_drive,
    output logic [GPIO_W-1:0]         core_output,
    output logic [GPIO_W-1:0]         core_drive
);

    localparam int DEPTH = 1 << IMEM_AW;

    logic [15:0] imem [DEPTH];
    logic [15:0] div_q [NUM_SM];
    logic [15:0] cnt_q [NUM_SM];
    logic [NUM_SM-1:0] hit;
    logic [GPIO_W-1:0] arb_output;
    logic [GPIO_W-1:0] arb_drive;

    // Memory is flop-based so that reset can clear every word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                imem[a] <= 16'h0000;
            end
        end else if (imem_wr_en) begin
            imem[imem_wr_addr] <= imem_wr_data;
        end
    end

    always_comb begin
        sm_instr = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            sm_instr[i*16 +: 16] = imem[sm_pc[i*IMEM_AW +: IMEM_AW]];
        end
    end

    // Terminal count is div-1 in 16-bit arithmetic, so div=0 wraps to
    // 16'hFFFF and naturally gives a period of 65536.
    // The strobe is gated by rst so it is held low during reset even though
    // counter==0 matches the reset divider of 1.
    always_comb begin
        hit       = '0;
        sm_clk_en = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            hit[i]       = (cnt_q[i] == (div_q[i] - 16'd1));
            sm_clk_en[i] = rst & sm_enable[i] & hit[i] & ~div_wr_en[i] & ~sm_restart[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SM; i++) begin
                div_q[i] <= 16'd1;
                cnt_q[i] <= 16'd0;
            end
            sm_restart_out <= '0;
        end else begin
            for (int i = 0; i < NUM_SM; i++) begin
                if (div_wr_en[i]) begin
                    div_q[i] <= div_value;
                end
                if (div_wr_en[i] || sm_restart[i]) begin
                    cnt_q[i] <= 16'd0;
                end else if (sm_enable[i]) begin
                    cnt_q[i] <= hit[i] ? 16'd0 : cnt_q[i] + 16'd1;
                end
            end
            sm_restart_out <= sm_restart;
        end
    end

    // Ascending scan: a later (higher-index) enabled driver overwrites
    // earlier ones, giving highest-index-wins per pin.
    always_comb begin
        logic [GPIO_W-1:0] m;
        arb_output = '0;
        arb_drive  = '0;
        m          = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            m          = {GPIO_W{sm_enable[i]}} & sm_drive[i*GPIO_W +: GPIO_W];
            arb_drive  = arb_drive | m;
            arb_output = (arb_output & ~m) | (sm_output[i*GPIO_W +: GPIO_W] & m);
        end
    end

`ifdef PIO_OUT_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_output <= '0;
            core_drive  <= '0;
        end else begin
            core_output <= arb_output;
            core_drive  <= arb_drive;
        end
    end
`else
    assign core_output = arb_output;
    assign core_drive  = arb_drive;
`endif

endmodule

// File: tb/tb_pio_sm_array_ctrl.sv
// tb/tb_pio_sm_array_ctrl.sv - directed self-checking bench for pio_sm_array_ctrl
module tb_pio_sm_array_ctrl;

    localparam int NUM_SM  = 4;
    localparam int IMEM_AW = 5;
    localparam int GPIO_W  = 32;

    logic                      clk;
    logic                      rst;
    logic                      imem_wr_en;
    logic [IMEM_AW-1:0]        imem_wr_addr;
    logic [15:0]               imem_wr_data;
    logic [NUM_SM*IMEM_AW-1:0] sm_pc;
    logic [NUM_SM*16-1:0]      sm_instr;
    logic [NUM_SM-1:0]         sm_enable;
    logic [NUM_SM-1:0]         sm_restart;
    logic [NUM_SM-1:0]         div_wr_en;
    logic [15:0]               div_value;
    logic [NUM_SM-1:0]         sm_clk_en;
    logic [NUM_SM-1:0]         sm_restart_out;
    logic [NUM_SM*GPIO_W-1:0]  sm_output;
    logic [NUM_SM*GPIO_W-1:0]  sm_drive;
    logic [GPIO_W-1:0]         core_output;
    logic [GPIO_W-1:0]         core_drive;

    int checks;
    int errors;

    pio_sm_array_ctrl #(.NUM_SM(NUM_SM), .IMEM_AW(IMEM_AW), .GPIO_W(GPIO_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_wr_en    (imem_wr_en),
        .imem_wr_addr  (imem_wr_addr),
        .imem_wr_data  (imem_wr_data),
        .sm_pc         (sm_pc),
        .sm_instr      (sm_instr),
        .sm_enable     (sm_enable),
        .sm_restart    (sm_restart),
        .div_wr_en     (div_wr_en),
        .div_value     (div_value),
        .sm_clk_en     (sm_clk_en),
        .sm_restart_out(sm_restart_out),
        .sm_output     (sm_output),
        .sm_drive      (sm_drive),
        .core_output   (core_output),
        .core_drive    (core_drive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        imem_wr_en = 1'b0; imem_wr_addr = '0; imem_wr_data = '0;
        sm_pc = '0; sm_enable = 4'hF; sm_restart = '0;
        div_wr_en = '0; div_value = '0; sm_output = '0; sm_drive = '0;
        #3;
        checks++;
        if (sm_clk_en !== 4'h0) begin
            errors++; $display("FAIL reset_clk_en actual=%h required=%h", sm_clk_en, 4'h0);
        end
        checks++;
        if (sm_restart_out !== 4'h0) begin
            errors++; $display("FAIL reset_restart_out actual=%h required=%h", sm_restart_out, 4'h0);
        end
        checks++;
        if (sm_instr !== 64'h0) begin
            errors++; $display("FAIL reset_instr actual=%h required=%h", sm_instr, 64'h0);
        end
        checks++;
        if (core_drive !== 32'h0 || core_output !== 32'h0) begin
            errors++; $display("FAIL reset_core actual=%h/%h required=0/0", core_drive, core_output);
        end
        tick();
        sm_enable = '0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_imem();
        imem_wr_en = 1'b1; imem_wr_addr = 5'd7; imem_wr_data = 16'hA5C3;
        sm_pc = {4{5'd7}};
        #1;
        checks++;
        if (sm_instr !== 64'h0) begin
            errors++; $display("FAIL imem_before_write actual=%h required=%h", sm_instr, 64'h0);
        end
        tick();
        imem_wr_addr = 5'd31; imem_wr_data = 16'h1234;
        #1;
        checks++;
        if (sm_instr !== {4{16'hA5C3}}) begin
            errors++; $display("FAIL imem_shared_read actual=%h required=%h", sm_instr, {4{16'hA5C3}});
        end
        tick();
        imem_wr_en = 1'b0;
        sm_pc = {5'd6, 5'd31, 5'd7, 5'd6};
        #1;
        checks++;
        if (sm_instr !== {16'h0000, 16'h1234, 16'hA5C3, 16'h0000}) begin
            errors++; $display("FAIL imem_mixed_read actual=%h required=%h", sm_instr,
                               {16'h0000, 16'h1234, 16'hA5C3, 16'h0000});
        end
        sm_pc = {4{5'd7}};
    endtask

    task automatic test_divider();
        sm_enable = '0; div_wr_en = 4'b0010; div_value = 16'd3;
        tick();
        div_wr_en = '0; sm_enable = 4'b0011;
        for (int c = 1; c <= 9; c++) begin
            #1;
            checks++;
            if (sm_clk_en[1] !== ((c % 3) == 0)) begin
                errors++; $display("FAIL div3_cycle%0d actual=%b required=%b", c, sm_clk_en[1], (c % 3) == 0);
            end
            checks++;
            if (sm_clk_en[0] !== 1'b1) begin
                errors++; $display("FAIL div1_cycle%0d actual=%b required=1", c, sm_clk_en[0]);
            end
            tick();
        end
        sm_enable = '0;
        #1;
        checks++;
        if (sm_clk_en !== 4'h0) begin
            errors++; $display("FAIL disabled_clk_en actual=%h required=0", sm_clk_en);
        end
    endtask

    task automatic test_restart();
        sm_enable = '0; div_wr_en = 4'b0100; div_value = 16'd4;
        tick();
        div_wr_en = '0; sm_enable = 4'b0100;
        tick();
        tick();
        sm_restart = 4'b0100;
        #1;
        checks++;
        if (sm_clk_en[2] !== 1'b0 || sm_restart_out[2] !== 1'b0) begin
            errors++; $display("FAIL restart_req_cycle actual=%b/%b required=0/0", sm_clk_en[2], sm_restart_out[2]);
        end
        tick();
        sm_restart = '0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (sm_restart_out[2] !== (k == 1) || sm_clk_en[2] !== (k == 4)) begin
                errors++; $display("FAIL restart_after%0d actual=%b/%b required=%b/%b", k,
                                   sm_restart_out[2], sm_clk_en[2], k == 1, k == 4);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_seq;
        exp_seq = 5'b01110;
        sm_enable = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            sm_restart[3] = (k < 3);
            #1;
            checks++;
            if (sm_restart_out[3] !== exp_seq[k]) begin
                errors++; $display("FAIL restart_held_c%0d actual=%b required=%b", k, sm_restart_out[3], exp_seq[k]);
            end
            tick();
        end
        sm_restart = '0;
        // Divider load and restart together: both take effect.
        sm_enable = 4'b0001; div_wr_en = 4'b0001; sm_restart = 4'b0001; div_value = 16'd2;
        #1;
        checks++;
        if (sm_clk_en[0] !== 1'b0) begin
            errors++; $display("FAIL both_req_clk_en actual=%b required=0", sm_clk_en[0]);
        end
        tick();
        div_wr_en = '0; sm_restart = '0;
        #1;
        checks++;
        if (sm_restart_out[0] !== 1'b1 || sm_clk_en[0] !== 1'b0) begin
            errors++; $display("FAIL both_next actual=%b/%b required=1/0", sm_restart_out[0], sm_clk_en[0]);
        end
        tick();
        checks++;
        if (sm_clk_en[0] !== 1'b1) begin
            errors++; $display("FAIL both_div2_strobe actual=%b required=1", sm_clk_en[0]);
        end
        sm_enable = '0;
        tick();
    endtask

    task automatic test_arbitration();
        sm_output = '0; sm_drive = '0;
        sm_output[0*GPIO_W + 5] = 1'b1; sm_drive[0*GPIO_W + 5] = 1'b1;
        sm_output[3*GPIO_W + 5] = 1'b0; sm_drive[3*GPIO_W + 5] = 1'b1;
        sm_output[1*GPIO_W + 9] = 1'b1; sm_drive[1*GPIO_W + 9] = 1'b1;
        sm_enable = 4'b1001;
`ifdef PIO_OUT_REG_EN
        tick();
`endif
        #1;
        checks++;
        if (core_drive !== 32'h20 || core_output !== 32'h0) begin
            errors++; $display("FAIL arb_both actual=%h/%h required=00000020/00000000", core_drive, core_output);
        end
        sm_enable = 4'b0001;
`ifdef PIO_OUT_REG_EN
        tick();
`endif
        #1;
        checks++;
        if (core_drive !== 32'h20 || core_output !== 32'h20) begin
            errors++; $display("FAIL arb_ch0 actual=%h/%h required=00000020/00000020", core_drive, core_output);
        end
        sm_enable = 4'b0011;
`ifdef PIO_OUT_REG_EN
        tick();
`endif
        #1;
        checks++;
        if (core_drive !== 32'h220 || core_output !== 32'h220) begin
            errors++; $display("FAIL arb_ch01 actual=%h/%h required=00000220/00000220", core_drive, core_output);
        end
        sm_enable = 4'b0000;
`ifdef PIO_OUT_REG_EN
        tick();
`endif
        #1;
        checks++;
        if (core_drive !== 32'h0 || core_output !== 32'h0) begin
            errors++; $display("FAIL arb_none actual=%h/%h required=0/0", core_drive, core_output);
        end
        sm_output = '0; sm_drive = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        sm_enable = '0; div_wr_en = 4'b0010; div_value = 16'd5;
        tick();
        div_wr_en = '0; sm_enable = 4'b0010; sm_restart = 4'b0100;
        tick();
        sm_restart = '0;
        tick();
        // sm_restart_out[2] is 0 again here; re-arm it so reset has to clear it.
        sm_restart = 4'b0100;
        tick();
        sm_restart = '0;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (sm_clk_en !== 4'h0 || sm_restart_out !== 4'h0) begin
            errors++; $display("FAIL midrst_outputs actual=%h/%h required=0/0", sm_clk_en, sm_restart_out);
        end
        checks++;
        if (sm_instr !== 64'h0) begin
            errors++; $display("FAIL midrst_imem actual=%h required=0", sm_instr);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (sm_clk_en[1] !== 1'b1) begin
                errors++; $display("FAIL post_rst_div1_c%0d actual=%b required=1", k, sm_clk_en[1]);
            end
            tick();
        end
        sm_enable = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_imem();
        test_divider();
        test_restart();
        test_back_to_back();
        test_arbitration();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
